// File: rtl/timer_setup_ctrl.sv
// Setup/run control for the MM:SS countdown timer: debounced buttons,
// minute-digit entry, load/CE generation and the mode code for the display.
module timer_setup_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       done,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic       load,
  output logic       CE,
  output logic       sel_digit,
  output logic [1:0] mode
);
  localparam int NUM_BTN = 4;
  localparam logic [1:0] M_SETUP = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_PAUSE = 2'b10;
  localparam logic [1:0] M_DONE  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Lane order: 0 inc, 1 sel, 2 start, 3 clr
  logic [NUM_BTN-1:0]            raw;
  logic [NUM_BTN-1:0]            sync1_q, sync2_q, level_q, level_d, press;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign raw = {btn_clr, btn_start, btn_sel, btn_inc};

  // Press fires on the cycle the debounced level commits to 1, so the FSM
  // acts on the same edge that updates the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          press[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  logic p_clr, p_start, p_sel, p_inc;
  assign p_clr   = press[3];
  assign p_start = press[2] & ~press[3];
  assign p_sel   = press[1] & ~|press[3:2];
  assign p_inc   = press[0] & ~|press[3:1];

  logic [1:0] mode_q, mode_d;
  logic       ce_q, ce_d, load_q, load_d, sel_q, sel_d;
  logic [3:0] min10_q, min10_d, min1_q, min1_d;

  function automatic logic [3:0] dec_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_comb begin
    mode_d  = mode_q;
    ce_d    = ce_q;
    load_d  = 1'b0;
    sel_d   = sel_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    if (p_clr) begin
      mode_d = M_SETUP;
      ce_d   = 1'b0;
    end else begin
      case (mode_q)
        M_SETUP: begin
          // The cycle carrying load commits the move to RUN.
          if (load_q) begin
            mode_d = M_RUN;
            ce_d   = 1'b1;
          end else if (p_start) begin
            load_d = (min10_q != 4'd0) || (min1_q != 4'd0);
          end else if (p_sel) begin
            sel_d = ~sel_q;
          end else if (p_inc) begin
            if (sel_q) min10_d = dec_inc(min10_q);
            else       min1_d  = dec_inc(min1_q);
          end
        end
        M_RUN: begin
          if (done) begin
            mode_d = M_DONE;
            ce_d   = 1'b0;
          end else if (p_start) begin
            mode_d = M_PAUSE;
            ce_d   = 1'b0;
          end
        end
        M_PAUSE: begin
          if (p_start) begin
            mode_d = M_RUN;
            ce_d   = 1'b1;
          end
        end
        default: begin
          if (p_start) mode_d = M_SETUP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= M_SETUP;
      ce_q    <= 1'b0;
      load_q  <= 1'b0;
      sel_q   <= 1'b0;
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
    end else begin
      mode_q  <= mode_d;
      ce_q    <= ce_d;
      load_q  <= load_d;
      sel_q   <= sel_d;
      min10_q <= min10_d;
      min1_q  <= min1_d;
    end
  end

  assign mode      = mode_q;
  assign CE        = ce_q;
  assign load      = load_q;
  assign sel_digit = sel_q;
  assign min10     = min10_q;
  assign min1      = min1_q;
endmodule

// File: tb/tb_timer_setup_ctrl.sv
// Directed bench for timer_setup_ctrl with a short debounce window.
module tb_timer_setup_ctrl;
  localparam int DB = 4;
  localparam logic [3:0] INC = 4'b0001, SEL = 4'b0010, STA = 4'b0100, CLR = 4'b1000;
  localparam int SETUP = 0, RUN = 1, PAUSE = 2, DONE = 3;

  logic       clk, reset, done;
  logic [3:0] btn;
  logic [3:0] min10, min1;
  logic       load, CE, sel_digit;
  logic [1:0] mode;

  timer_setup_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .clk(clk), .reset(reset),
    .btn_sel(btn[1]), .btn_inc(btn[0]), .btn_start(btn[2]), .btn_clr(btn[3]),
    .done(done),
    .min10(min10), .min1(min1), .load(load), .CE(CE),
    .sel_digit(sel_digit), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    int mode, ce, m10, m1, sel, loads;
  } vec_t;

  int   n_cmp = 0, n_fail = 0, load_cnt = 0;
  logic load_prev = 1'b0;
  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] b, input int md, input int ce,
                              input int m10, input int m1, input int sel, input int ld);
    vec_t v;
    v.btn = b; v.mode = md; v.ce = ce; v.m10 = m10; v.m1 = m1; v.sel = sel; v.loads = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle, sample at the falling edge, check load invariants.
  task automatic tick();
    @(negedge clk);
    if (load) load_cnt++;
    chk("load_with_ce", int'(load && CE), 0);
    chk("load_back_to_back", int'(load && load_prev), 0);
    load_prev = load;
  endtask

  task automatic press(input logic [3:0] m);
    load_cnt = 0;
    btn = m;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
  endtask

  task automatic chk_all(input string tag, input int md, input int ce, input int m10,
                         input int m1, input int sel, input int ld);
    chk({tag, ".mode"}, int'(mode), md);
    chk({tag, ".CE"}, int'(CE), ce);
    chk({tag, ".min10"}, int'(min10), m10);
    chk({tag, ".min1"}, int'(min1), m1);
    chk({tag, ".sel_digit"}, int'(sel_digit), sel);
    chk({tag, ".loads"}, load_cnt, ld);
  endtask

  int found;

  initial begin
    reset = 1'b0; done = 1'b0; btn = '0;
    repeat (3) tick();
    load_cnt = 0;
    chk_all("reset", SETUP, 0, 0, 0, 0, 0);
    chk("reset.load", int'(load), 0);
    reset = 1'b1;

    // 3-cycle glitch must be filtered out
    btn[0] = 1'b1;
    repeat (3) tick();
    btn[0] = 1'b0;
    repeat (10) tick();
    chk("glitch.min1", int'(min1), 0);

    // Held press: increment lands exactly 6 cycles after the raw edge
    btn[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("hold.min1.c%0d", k), int'(min1), (k >= 6) ? 1 : 0);
    end
    btn[0] = 1'b0;
    repeat (10) tick();
    chk("hold.single", int'(min1), 1);

    // Zero-time start is ignored
    reset = 1'b0; tick(); reset = 1'b1;
    press(STA);
    chk_all("zero_start", SETUP, 0, 0, 0, 0, 0);

    for (int k = 1; k <= 9; k++) vq.push_back(mk(INC, SETUP, 0, 0, k, 0, 0));
    vq.push_back(mk(INC, SETUP, 0, 0, 0, 0, 0));
    vq.push_back(mk(SEL, SETUP, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 9; k++) vq.push_back(mk(INC, SETUP, 0, k, 0, 1, 0));
    vq.push_back(mk(INC, SETUP, 0, 0, 0, 1, 0));
    vq.push_back(mk(SEL, SETUP, 0, 0, 0, 0, 0));
    vq.push_back(mk(STA, SETUP, 0, 0, 0, 0, 0));
    vq.push_back(mk(INC, SETUP, 0, 0, 1, 0, 0));
    vq.push_back(mk(INC, SETUP, 0, 0, 2, 0, 0));
    vq.push_back(mk(SEL | INC, SETUP, 0, 0, 2, 1, 0));
    vq.push_back(mk(SEL, SETUP, 0, 0, 2, 0, 0));
    vq.push_back(mk(STA, RUN, 1, 0, 2, 0, 1));
    vq.push_back(mk(SEL, RUN, 1, 0, 2, 0, 0));
    vq.push_back(mk(INC, RUN, 1, 0, 2, 0, 0));
    vq.push_back(mk(STA, PAUSE, 0, 0, 2, 0, 0));
    vq.push_back(mk(INC, PAUSE, 0, 0, 2, 0, 0));
    vq.push_back(mk(SEL, PAUSE, 0, 0, 2, 0, 0));
    vq.push_back(mk(STA, RUN, 1, 0, 2, 0, 0));
    vq.push_back(mk(STA | SEL | INC, PAUSE, 0, 0, 2, 0, 0));
    vq.push_back(mk(STA, RUN, 1, 0, 2, 0, 0));
    vq.push_back(mk(CLR | STA, SETUP, 0, 0, 2, 0, 0));
    vq.push_back(mk(INC, SETUP, 0, 0, 3, 0, 0));

    foreach (vq[i]) begin
      press(vq[i].btn);
      chk_all($sformatf("vec%0d", i), vq[i].mode, vq[i].ce, vq[i].m10, vq[i].m1,
              vq[i].sel, vq[i].loads);
    end

    // Load is a lone cycle in SETUP, followed directly by RUN with CE
    btn = STA;
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      tick();
      if (load) found = 1;
    end
    chk("load.seen", found, 1);
    chk("load.mode", int'(mode), SETUP);
    chk("load.CE", int'(CE), 0);
    tick();
    chk("post_load.load", int'(load), 0);
    chk("post_load.CE", int'(CE), 1);
    chk("post_load.mode", int'(mode), RUN);
    btn = '0;
    repeat (8) tick();

    // Terminal count, then done ignored in DONE, then back to SETUP
    done = 1'b1; tick(); done = 1'b0;
    chk("done.mode", int'(mode), DONE);
    chk("done.CE", int'(CE), 0);
    done = 1'b1; tick(); done = 1'b0;
    chk("done_again.mode", int'(mode), DONE);
    press(STA);
    chk_all("done_exit", SETUP, 0, 0, 3, 0, 0);

    // Reset mid-run
    press(STA);
    chk("rerun.mode", int'(mode), RUN);
    reset = 1'b0; tick();
    load_cnt = 0;
    chk_all("midreset", SETUP, 0, 0, 0, 0, 0);
    chk("midreset.load", int'(load), 0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_setup_ctrl.md
Name: timer_setup_ctrl

Overview:
- Front-end control stage that feeds the MM:SS countdown timer.
- Debounces four push buttons and lets the user enter the two minute digits (tens, units).
- Issues the one-cycle load pulse and the run enable (CE) to the timer datapath, and consumes the timer's terminal-count flag.
- Exports a mode code that the display stage uses for text/blink selection.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level change is accepted (10 ms at 100 MHz; benches use 4).
- CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- btn_sel  in  1  raw button: toggle selected digit.
- btn_inc  in  1  raw button: increment selected digit.
- btn_start  in  1  raw button: start/pause/resume.
- btn_clr  in  1  raw button: abort to setup.
- done  in  1  timer terminal-count flag (timer reached 00:00).
- min10  out  4  tens-of-minutes digit, always 0..9.
- min1  out  4  units-of-minutes digit, always 0..9.
- load  out  1  one-cycle load strobe to the timer counters.
- CE  out  1  count enable to the timer.
- sel_digit  out  1  0 = min1 selected, 1 = min10 selected.
- mode  out  2  00 SETUP, 01 RUN, 10 PAUSE, 11 DONE.

Behaviour:
- Reset (reset==0 at a clk edge) clears: mode=SETUP, min10=0, min1=0, sel_digit=0, load=0, CE=0, all synchronizer flops, debounce counters, debounced levels and press pulses. Reset has priority over everything and may occur in any state.
- Input path, per button: 2-flop synchronizer, then debouncer.
  - Debounce counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced value and the counter clears.
  - A press pulse (1 cycle) is generated on the debounced 0->1 transition only. Release produces no pulse.
  - Latency from raw edge to pulse: 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Press priority within a cycle: clr > start > sel > inc. Only the highest-priority pulse is acted on; the others are dropped.
- SETUP (CE=0):
  - inc increments the selected digit; 9 wraps to 0; the other digit is unchanged.
  - sel toggles sel_digit.
  - start with min10==0 and min1==0 is ignored.
  - Otherwise start asserts load for exactly the next cycle; mode=RUN and CE=1 from the cycle after load.
- RUN (CE=1):
  - done==1 -> DONE with CE=0 next cycle. done takes priority over a start press in the same cycle, but not over clr.
  - start -> PAUSE, CE=0 next cycle.
  - inc and sel are ignored.
- PAUSE (CE=0):
  - start -> RUN, CE=1 next cycle; no reload.
  - inc and sel are ignored.
- DONE (CE=0):
  - start -> SETUP; the digits keep their last entered values for quick re-run.
  - done is ignored in this state.
- clr in any state -> SETUP next cycle: CE=0, load=0, digits and sel_digit retained.
- min10/min1 change only in SETUP on an inc pulse and never leave 0..9.
- load is never asserted outside the SETUP->RUN transition, and never two cycles back to back.
- CE and load are never high in the same cycle.
- Outputs are registered. mode, CE and load change only on clk edges.

Test Plan (DEBOUNCE_CYCLES=4):
- Debounce: hold reset low 3 cycles, then btn_inc pulse 3 cycles wide -> no change, min1=0. Then hold btn_inc high 10 cycles -> min1=1 exactly 6 cycles after the rising edge, single increment.
- Entry and wrap: 10 inc presses -> min1 9 then 0. Press sel, then 3 inc presses -> sel_digit=1, min10=3, min1=0.
- Zero start: reset, press start -> load stays 0, mode=00, CE=0.
- Start/pause/resume: set min10=0, min1=2, press start -> load=1 for one cycle, next cycle CE=1 and mode=01. Press start -> CE=0, mode=10, load=0. Press start -> CE=1, mode=01, no load.
- Done: in RUN, assert done 1 cycle -> next cycle CE=0, mode=11. Press start -> mode=00, min1=2 retained.
- Abort and reset: in RUN, press clr and start simultaneously -> mode=00, CE=0, no load. Drive reset=0 mid-RUN -> next edge: all outputs 0, mode=00.
